// File: rtl/rr_priority_arbiter_4.sv
// Four-way arbiter with fixed-priority or round-robin selection, grant hold and
// hold-timeout preemption. All outputs are registered.
module rr_priority_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode_rr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       last_id_q, last_id_d;

  logic [3:0] others;
  logic       owner_req;
  logic       timeout;
  logic [2:0] win_all;
  logic [2:0] win_oth;
  logic       do_grant;
  logic [1:0] sel_id;

  // Returns {found, index}; RR searches from last+1 with last itself tried last.
  function automatic logic [2:0] pick(input logic [3:0] cand, input logic rr,
                                      input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    if (rr) begin
      for (int i = 4; i >= 1; i--) begin
        idx = last + 2'(i);
        if (cand[idx]) res = {1'b1, idx};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cand[i]) res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  assign others    = req & ~gnt_q;
  assign owner_req = req[gnt_id_q];
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
  assign win_all   = pick(req, mode_rr, last_id_q);
  assign win_oth   = pick(others, mode_rr, last_id_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;
    do_grant    = 1'b0;
    sel_id      = 2'd0;

    case (state_q)
      IDLE: begin
        if (win_all[2]) begin
          do_grant = 1'b1;
          sel_id   = win_all[1:0];
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_all[2]) begin
            do_grant = 1'b1;
            sel_id   = win_all[1:0];
          end else begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_id_d    = 2'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (timeout && (others != 4'b0000)) begin
          do_grant  = 1'b1;
          sel_id    = win_oth[1:0];
          preempt_d = 1'b1;
        end else if (!timeout && (hold_cnt_q != '1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d     = GRANT;
      gnt_d       = 4'b0001 << sel_id;
      gnt_id_d    = sel_id;
      gnt_valid_d = 1'b1;
      hold_cnt_d  = CNT_W'(1);
      last_id_d   = sel_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_id_q   <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: doc/rr_priority_arbiter_4.md
Name: rr_priority_arbiter_4

Overview:
- Shares one resource among 4 requesters; issues a registered one-hot grant plus an encoded grant ID.
- Two arbitration modes: fixed priority (req[3] highest, same ordering as the team's 4x2 priority encoder) or round-robin.
- A grant is held until the owner drops its request or a hold-timeout forces re-arbitration.
- Sits in front of a shared datapath; gnt_id drives the resource mux select, gnt_valid drives its enable.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles while others wait; 0 disables timeout.
- CNT_W, 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request vector, level-sensitive; requester holds high while it wants the resource.
- mode_rr, input, 1: 1 = round-robin, 0 = fixed priority.
- gnt, output, 4: registered one-hot grant; all-zero when idle.
- gnt_id, output, 2: encoded index of gnt; valid only when gnt_valid=1.
- gnt_valid, output, 1: 1 when any grant is active.
- preempt, output, 1: one-cycle pulse in the cycle a timeout revokes a grant from a still-requesting owner.

Behaviour:
- Reset (async assert, sync-safe release):
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - State=IDLE, hold_cnt=0, last_id=3. With last_id=3, the first RR search order is 0,1,2,3.
- Winner selection (combinational, used at arbitration events only):
  - Fixed mode: highest-index asserted request in the candidate set.
  - RR mode: first asserted request searching last_id+1, last_id+2, ... with wrap modulo 4.
- State IDLE:
  - If req != 0: winner registered on the next clock edge. gnt, gnt_id and gnt_valid go high 1 cycle after req is sampled.
  - Same edge: state->GRANT, hold_cnt=1, last_id=winner.
  - If req == 0: outputs stay zero.
- State GRANT (owner = gnt_id), evaluated each cycle in priority order:
  1. Release, req[owner]=0:
     - Re-arbitrate over req.
     - If req != 0: new grant next cycle, back-to-back with no idle gap; hold_cnt=1, last_id updated.
     - If req == 0: gnt=0, gnt_valid=0, state->IDLE.
  2. Timeout: req[owner]=1, MAX_HOLD != 0, hold_cnt==MAX_HOLD, and (req & ~gnt) != 0:
     - Winner chosen from req excluding owner, in either mode.
     - Grant moves next cycle; preempt=1 for that one cycle; hold_cnt=1; last_id updated.
  3. Timeout with no other requester: owner keeps the grant, hold_cnt stays at MAX_HOLD (saturates), preempt=0.
  4. Otherwise: grant held, hold_cnt increments.
- Timeout is tested and preempt fires only in the timeout-with-others case (rule 2).
- mode_rr is sampled only at arbitration events. Changing it mid-grant does not disturb the current owner.
- gnt is always one-hot or zero. gnt_id equals encode(gnt) when gnt_valid=1, otherwise 0.
- New requests arriving during GRANT never preempt, except via the timeout rule.
- Reset mid-grant: all outputs drop to reset values asynchronously; last_id returns to 3.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Release to next grant: 1 cycle.
  - Release to idle: 1 cycle.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, preempt=0 throughout; assert rst_n low mid-grant -> gnt=0 immediately, without waiting for a clock edge.
- mode_rr=0, req=4'b0110 -> gnt=4'b0100, gnt_id=2 one cycle later; raise req[3] while req[2] is held -> no change; drop req[2] -> next cycle gnt=4'b1000, gnt_id=3.
- mode_rr=1, all four requesters assert and each drops its request 2 cycles after being granted -> grant order 0,1,2,3,0, with back-to-back grants and gnt_valid continuously high.
- mode_rr=1, MAX_HOLD=8, req=4'b0011 held constant -> id0 granted for 8 cycles, then preempt pulses for 1 cycle and gnt=4'b0010; 8 cycles later, grant returns to id0.
- MAX_HOLD=8, req=4'b0100 alone for 20 cycles -> gnt stays 4'b0100 for all 20 cycles, preempt never asserts; then raise req[0] -> grant moves on the next edge with preempt=1 (counter already saturated).
- Single-cycle pulse req=4'b0001 from IDLE -> gnt=4'b0001 for exactly 1 cycle, then idle; change mode_rr during a held grant -> owner is unchanged.
